piso_chain: RTL and testbench
=============================

PISO_CHAIN -- requirements
Module: piso_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per cascaded stage.
REQ-002 SHALL have parameter DEPTH, default 2, number of cascaded stages; total length N = WIDTH*DEPTH.
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 = bit 0 shifted out first, 1 = bit N-1 shifted out first.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request load-and-shift of parin; honoured only in IDLE.
REQ-007 SHALL have port parin  input  N  parallel load word.
REQ-008 SHALL have port en  input  1  shift enable; one bit consumed per cycle en=1 in SHIFT.
REQ-009 SHALL have port ser  input  1  serial in, sampled on each shifting edge.
REQ-010 SHALL have port abort  input  1  cancels transfer in progress.
REQ-011 SHALL have port q  output  1  current serial output bit.
REQ-012 SHALL have port q_n  output  1  always ~q.
REQ-013 SHALL have port busy  output  1  high in LOAD-completed SHIFT state.
REQ-014 SHALL have port done  output  1  one-cycle pulse, transfer complete.
REQ-015 SHALL have port dout  output  N  word collected from ser, valid when done=1, held until next done.

Function
REQ-016 SHALL implement states IDLE, SHIFT, DONE; registered outputs; no combinational path from inputs to q.
REQ-017 SHALL load parin synchronously on the edge where state=IDLE and start=1; state->SHIFT, bit counter<=N.
REQ-018 SHALL present first bit on q the cycle after the load edge: data[0] if MSB_FIRST=0, data[N-1] if 1.
REQ-019 SHALL, in SHIFT with en=1, shift data one place toward the output end and insert ser at the far end (data[N-1] if MSB_FIRST=0, data[0] if 1), decrement counter.
REQ-020 SHALL hold data, counter and q unchanged in SHIFT while en=0 (stall indefinitely).
REQ-021 SHALL, on the shifting edge where counter=1, go to DONE, set counter 0 and write dout with the post-shift data (N ser bits, first-received bit at output end).
REQ-022 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-023 SHALL ignore start in SHIFT and DONE; start held high through DONE begins a new load on the first IDLE edge.
REQ-024 SHALL, on abort=1 in SHIFT, go to IDLE next edge, no done, dout unchanged; abort wins over simultaneous en; abort ignored in IDLE/DONE.
REQ-025 SHALL keep q showing the output-end bit of data in all states; data retained in IDLE.
REQ-026 SHALL size counter to $clog2(N+1) bits; no wrap occurs since counter never decrements below 0.
REQ-027 SHALL support N=1 (one shifting edge completes the transfer).

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, data 0, counter 0, dout 0, done 0, busy 0, q 0, q_n 1, independent of clk.
REQ-029 SHALL abandon any transfer on reset mid-operation, no done pulse; first load allowed on first edge after rst_n rises with start=1.

Verification
REQ-030 SHALL cover: WIDTH=8 DEPTH=2 MSB_FIRST=0, parin=16'hA5C3, start 1 cycle, en=1, ser=1 -> q 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles, busy 16 cycles, done 1 cycle, dout=16'hFFFF.
REQ-031 SHALL cover: same with MSB_FIRST=1, ser alternating 1,0 starting 1 -> q 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; dout=16'hAAAA.
REQ-032 SHALL cover: en toggled 1,0 each cycle -> each q bit held 2 cycles, done after 32 cycles in SHIFT, dout unaffected by ser when en=0.
REQ-033 SHALL cover: abort after 5 shifts with en=1 same cycle -> IDLE next edge, done never asserts, dout keeps prior value, q frozen.
REQ-034 SHALL cover: rst_n low mid-SHIFT asynchronously between edges -> q=0, q_n=1, busy=0 immediately; new start after release runs full 16-bit transfer.
REQ-035 SHALL cover: start held high continuously -> back-to-back transfers, one IDLE cycle between done and next busy, start pulses during SHIFT ignored.

Source files
------------

// File: rtl/piso_chain.sv
// piso_chain: cascaded parallel-in / serial-out shift register of N = WIDTH*DEPTH
// bits that simultaneously collects a serial word.
//   A start request in IDLE loads parin. Each en=1 cycle in SHIFT then moves the
//   word one place toward the output end and inserts ser at the far end. After N
//   shifts the collected word appears on dout and done pulses for one cycle.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - load-and-shift request (honoured in IDLE only)
//   parin  - parallel load word [N-1:0]
//   en     - shift enable (one bit per enabled cycle)
//   ser    - serial input, sampled on each shifting edge
//   abort  - cancels a transfer in SHIFT
//   q/q_n  - current output-end bit and its complement
//   busy   - high while in SHIFT
//   done   - one-cycle completion pulse
//   dout   - collected serial word, held until the next completion
module piso_chain #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 2,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH*DEPTH-1:0] parin,
  input  logic                   en,
  input  logic                   ser,
  input  logic                   abort,
  output logic                   q,
  output logic                   q_n,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*DEPTH-1:0] dout
);

  localparam int unsigned N       = WIDTH * DEPTH;
  localparam int unsigned CW      = $clog2(N + 1);
  // Output end and insertion end of the data register.
  localparam int unsigned OUT_IDX = MSB_FIRST ? N - 1 : 0;
  localparam int unsigned IN_IDX  = MSB_FIRST ? 0 : N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [N-1:0]   dout_q, dout_d;
  logic [N-1:0]   shifted;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, done_q;

  // Shift toward the output end, then overwrite the vacated far-end bit with ser.
  // Expressed as shift-then-insert so that N=1 needs no special case.
  always_comb begin
    shifted          = MSB_FIRST ? (data_q << 1) : (data_q >> 1);
    shifted[IN_IDX]  = ser;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          data_d  = parin;
          cnt_d   = CW'(N);
        end
      end
      SHIFT: begin
        // abort takes priority over a simultaneous shift; data stays frozen.
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (en) begin
          data_d = shifted;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            dout_d  = shifted;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      // Status flags registered from the next state so they line up with state_q.
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign q    = data_q[OUT_IDX];
  assign q_n  = ~data_q[OUT_IDX];
  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_piso_chain.sv
// Bench for piso_chain: LSB-first and MSB-first 16-bit instances share stimulus,
// a third 1-bit instance covers the N=1 case. Expected q/dout come from the
// transfer rules (bit s of parin after s shifts, collected ser bits ordered by
// arrival), not from a cycle model of the register.
module tb_piso_chain;

  logic        clk, rst_n;
  logic        start, en, ser, abort;
  logic [15:0] parin;
  logic        q0, qn0, busy0, done0;
  logic        q1, qn1, busy1, done1;
  logic [15:0] dout0, dout1;

  logic        start2, en2, ser2, abort2;
  logic [0:0]  parin2;
  logic        q2, qn2, busy2, done2;
  logic [0:0]  dout2;

  int total = 0;
  int bad   = 0;
  logic [15:0] mdout0 = '0;
  logic [15:0] mdout1 = '0;

  piso_chain #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .parin(parin), .en(en), .ser(ser),
    .abort(abort), .q(q0), .q_n(qn0), .busy(busy0), .done(done0), .dout(dout0));

  piso_chain #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .parin(parin), .en(en), .ser(ser),
    .abort(abort), .q(q1), .q_n(qn1), .busy(busy1), .done(done1), .dout(dout1));

  piso_chain #(.WIDTH(1), .DEPTH(1), .MSB_FIRST(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start2), .parin(parin2), .en(en2), .ser(ser2),
    .abort(abort2), .q(q2), .q_n(qn2), .busy(busy2), .done(done2), .dout(dout2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transfer on both 16-bit instances.
  // en_mode: 0 always 1, 1 toggle starting 0, 2 random.
  // ser_mode: 0 random, 1 all ones, 2 alternating starting 1.
  // abort_at: shift count at which abort (with en=1) is applied, -1 for none.
  // hold: keep start high throughout and scramble parin during SHIFT.
  task automatic xfer(input logic [15:0] pw, input int en_mode, input int ser_mode,
                      input int abort_at, input bit hold);
    bit          hist[$];
    int          s, cyc;
    logic        e0q, e1q;
    logic [15:0] e0, e1;
    total++;
    if ({busy0, done0, busy1, done1} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_entry: got %b exp 0000", {busy0, done0, busy1, done1});
    end
    start = 1'b1; parin = pw; abort = 1'b0; en = 1'($urandom); ser = 1'($urandom);
    @(negedge clk);
    if (!hold) start = 1'b0;
    s = 0; cyc = 0;
    while (s < 16 && cyc < 100) begin
      e0q = pw[s]; e1q = pw[15-s];
      total++;
      if ({busy0, done0, busy1, done1} !== 4'b1010) begin
        bad++;
        $display("FAIL shift_status s=%0d: got %b exp 1010", s, {busy0, done0, busy1, done1});
      end
      total++;
      if ({q0, qn0, q1, qn1} !== {e0q, ~e0q, e1q, ~e1q}) begin
        bad++;
        $display("FAIL shift_q s=%0d: got %b exp %b", s, {q0, qn0, q1, qn1}, {e0q, ~e0q, e1q, ~e1q});
      end
      if (abort_at == s) begin
        abort = 1'b1; en = 1'b1; ser = 1'($urandom);
        @(negedge clk);
        abort = 1'b0; en = 1'b0;
        total++;
        if ({busy0, done0, busy1, done1, q0, q1} !== {4'b0000, e0q, e1q}) begin
          bad++;
          $display("FAIL abort_state: got %b exp %b", {busy0, done0, busy1, done1, q0, q1}, {4'b0000, e0q, e1q});
        end
        total++;
        if ({dout0, dout1} !== {mdout0, mdout1}) begin
          bad++;
          $display("FAIL abort_dout: got %h %h exp %h %h", dout0, dout1, mdout0, mdout1);
        end
        @(negedge clk);
        total++;
        if ({busy0, done0, busy1, done1, q0, q1} !== {4'b0000, e0q, e1q}) begin
          bad++;
          $display("FAIL abort_after: got %b exp %b", {busy0, done0, busy1, done1, q0, q1}, {4'b0000, e0q, e1q});
        end
        return;
      end
      case (en_mode)
        0:       en = 1'b1;
        1:       en = ((cyc % 2) == 1);
        default: en = ($urandom_range(3) != 0);
      endcase
      case (ser_mode)
        1:       ser = 1'b1;
        2:       ser = ((hist.size() % 2) == 0);
        default: ser = 1'($urandom);
      endcase
      if (hold) parin = 16'($urandom);
      if (en) hist.push_back(ser);
      @(negedge clk);
      cyc++;
      if (en) s++;
    end
    en = 1'b0;
    if (s < 16) begin
      total++; bad++;
      $display("FAIL shift_timeout: got %0d shifts exp 16", s);
      return;
    end
    for (int i = 0; i < 16; i++) begin
      e0[i]    = hist[i];
      e1[15-i] = hist[i];
    end
    mdout0 = e0; mdout1 = e1;
    total++;
    if ({busy0, done0, busy1, done1} !== 4'b0101) begin
      bad++;
      $display("FAIL done_status: got %b exp 0101", {busy0, done0, busy1, done1});
    end
    total++;
    if ({dout0, dout1} !== {e0, e1}) begin
      bad++;
      $display("FAIL done_dout: got %h %h exp %h %h", dout0, dout1, e0, e1);
    end
    total++;
    if ({q0, qn0, q1, qn1} !== {hist[0], ~hist[0], hist[0], ~hist[0]}) begin
      bad++;
      $display("FAIL done_q: got %b exp %b", {q0, qn0, q1, qn1}, {hist[0], ~hist[0], hist[0], ~hist[0]});
    end
    @(negedge clk);
    total++;
    if ({busy0, done0, busy1, done1, dout0, dout1} !== {4'b0000, e0, e1}) begin
      bad++;
      $display("FAIL after_done: got %b %h %h exp 0000 %h %h", {busy0, done0, busy1, done1}, dout0, dout1, e0, e1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; en = 0; ser = 0; abort = 0; parin = '0;
    start2 = 0; en2 = 0; ser2 = 0; abort2 = 0; parin2 = '0;
    #3;
    total++;
    if ({q0, qn0, busy0, done0, q1, qn1, busy1, done1, q2, qn2, busy2, done2} !== 12'b010001000100) begin
      bad++;
      $display("FAIL reset_flags: got %b exp 010001000100", {q0, qn0, busy0, done0, q1, qn1, busy1, done1, q2, qn2, busy2, done2});
    end
    total++;
    if ({dout0, dout1, dout2} !== 33'd0) begin
      bad++;
      $display("FAIL reset_dout: got %h %h %h exp 0", dout0, dout1, dout2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lsb_pattern;
    xfer(16'hA5C3, 0, 1, -1, 1'b0);
  endtask

  task automatic test_msb_pattern;
    xfer(16'hA5C3, 0, 2, -1, 1'b0);
  endtask

  task automatic test_stall;
    xfer(16'($urandom), 1, 0, -1, 1'b0);
  endtask

  task automatic test_random;
    repeat (4) xfer(16'($urandom), 2, 0, -1, 1'b0);
  endtask

  task automatic test_abort;
    xfer(16'($urandom), 0, 0, 5, 1'b0);
    xfer(16'($urandom), 2, 0, int'($urandom_range(15)), 1'b0);
    xfer(16'($urandom), 0, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid;
    start = 1'b1; parin = 16'($urandom);
    @(negedge clk);
    start = 1'b0; en = 1'b1; ser = 1'($urandom);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    mdout0 = '0; mdout1 = '0;
    total++;
    if ({q0, qn0, busy0, done0, q1, qn1, busy1, done1} !== 8'b01000100) begin
      bad++;
      $display("FAIL reset_mid_flags: got %b exp 01000100", {q0, qn0, busy0, done0, q1, qn1, busy1, done1});
    end
    total++;
    if ({dout0, dout1} !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_dout: got %h %h exp 0", dout0, dout1);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(16'($urandom), 0, 0, -1, 1'b0);
  endtask

  task automatic test_back_to_back;
    repeat (3) xfer(16'($urandom), 0, 0, -1, 1'b1);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_n1;
    logic p, b;
    repeat (6) begin
      p = 1'($urandom);
      start2 = 1'b1; parin2 = p;
      @(negedge clk);
      start2 = 1'b0; en2 = 1'b0; ser2 = 1'($urandom);
      total++;
      if ({busy2, done2, q2, qn2} !== {2'b10, p, ~p}) begin
        bad++;
        $display("FAIL n1_load: got %b exp %b", {busy2, done2, q2, qn2}, {2'b10, p, ~p});
      end
      @(negedge clk);
      total++;
      if ({busy2, done2, q2} !== {2'b10, p}) begin
        bad++;
        $display("FAIL n1_stall: got %b exp %b", {busy2, done2, q2}, {2'b10, p});
      end
      b = 1'($urandom);
      en2 = 1'b1; ser2 = b;
      @(negedge clk);
      en2 = 1'b0;
      total++;
      if ({busy2, done2, q2, dout2} !== {2'b01, b, b}) begin
        bad++;
        $display("FAIL n1_done: got %b exp %b", {busy2, done2, q2, dout2}, {2'b01, b, b});
      end
      @(negedge clk);
      total++;
      if ({busy2, done2, dout2} !== {2'b00, b}) begin
        bad++;
        $display("FAIL n1_idle: got %b exp %b", {busy2, done2, dout2}, {2'b00, b});
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_pattern();
    test_msb_pattern();
    test_stall();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
